// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared types and default widths for the pipeline hazard controller
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Memory-wait state machine encoding
  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hazard_state_e;

  localparam int c_REG_ADDR_W_DEF = 5;
  localparam int c_WAIT_MAX_DEF   = 255;
  localparam int c_CNT_W_DEF      = 16;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones, with synchronous clear
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter
  import hazard_pkg::*;
#(
  parameter int WIDTH = c_CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] r_count;

  // Count requested events, holding at the maximum instead of wrapping
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      r_count <= '0;
    end else if (inc_i && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count_o = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline hazard controller: load-use stall, branch flush and
//            data-memory wait freeze with timeout watchdog and perf counters
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = c_REG_ADDR_W_DEF,
  parameter int WAIT_MAX   = c_WAIT_MAX_DEF,
  parameter int CNT_W      = c_CNT_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic                  ex_mem_read_i,
  input  logic                  ex_branch_taken_i,
  input  logic                  mem_access_i,
  input  logic                  dmem_ready_i,
  output logic                  pc_write_o,
  output logic                  ifid_valid_o,
  output logic                  idex_valid_o,
  output logic                  exmem_valid_o,
  output logic                  memwb_valid_o,
  output logic                  ifid_flush_o,
  output logic                  idex_flush_o,
  output logic                  exmem_flush_o,
  output logic                  memwb_flush_o,
  output logic                  timeout_o,
  output logic [CNT_W-1:0]      stall_cycles_o,
  output logic [CNT_W-1:0]      flush_events_o
);

  localparam int              c_CW       = $clog2(WAIT_MAX + 1);
  localparam logic [c_CW-1:0] c_WAIT_MAX = c_CW'(WAIT_MAX);
  localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);

  hazard_state_e   r_state;
  logic [c_CW-1:0] r_wait_cnt;
  logic            r_timeout;

  logic            w_freeze;
  logic            w_load_use;
  logic            w_branch_apply;
  logic [c_CW-1:0] w_cnt_inc;

  // Hazard detection; a freeze masks branch and load-use for this cycle
  assign w_freeze       = mem_access_i & ~dmem_ready_i;
  assign w_load_use     = ex_mem_read_i & (ex_rt_i != '0) &
                          ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));
  assign w_branch_apply = ~rst_i & ~w_freeze & ex_branch_taken_i;
  assign w_cnt_inc      = (r_wait_cnt == c_WAIT_MAX) ? r_wait_cnt : r_wait_cnt + c_ONE;

  // Priority mux for the pipe-register strobes: reset > freeze > branch > load-use
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_valid_o  = 1'b1;
    idex_valid_o  = 1'b1;
    exmem_valid_o = 1'b1;
    memwb_valid_o = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    memwb_flush_o = 1'b0;
    if (rst_i) begin
      pc_write_o    = 1'b0;
      ifid_valid_o  = 1'b0;
      idex_valid_o  = 1'b0;
      exmem_valid_o = 1'b0;
      memwb_valid_o = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
      memwb_flush_o = 1'b1;
    end else if (w_freeze) begin
      // Hold IF..MEM, push a bubble into WB
      pc_write_o    = 1'b0;
      ifid_valid_o  = 1'b0;
      idex_valid_o  = 1'b0;
      exmem_valid_o = 1'b0;
      memwb_flush_o = 1'b1;
    end else if (ex_branch_taken_i) begin
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
    end else if (w_load_use) begin
      // Hold PC and IF/ID, insert a bubble into EX
      pc_write_o    = 1'b0;
      ifid_valid_o  = 1'b0;
      idex_flush_o  = 1'b1;
    end
  end

  // Memory-wait FSM with saturating wait counter and sticky timeout
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_freeze) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= c_ONE;
            if (c_ONE == c_WAIT_MAX) begin
              r_timeout <= 1'b1;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (!dmem_ready_i) begin
            r_wait_cnt <= w_cnt_inc;
            if (w_cnt_inc == c_WAIT_MAX) begin
              r_timeout <= 1'b1;
            end
          end else begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign timeout_o = r_timeout;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .clear_i (rst_i),
    .inc_i   (~pc_write_o),
    .count_o (stall_cycles_o)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_flush_cnt (
    .clk_i   (clk_i),
    .clear_i (rst_i),
    .inc_i   (w_branch_apply),
    .count_o (flush_events_o)
  );

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Scoreboard bench for hazard_ctrl with a cycle-level reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int c_WAIT_MAX = 4;
  localparam int c_CNT_W    = 6;
  localparam int c_CNT_MAX  = (1 << c_CNT_W) - 1;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [4:0] id_rs_i = '0, id_rt_i = '0, ex_rt_i = '0;
  logic       ex_mem_read_i = 1'b0, ex_branch_taken_i = 1'b0;
  logic       mem_access_i = 1'b0, dmem_ready_i = 1'b1;
  logic       pc_write_o, ifid_valid_o, idex_valid_o, exmem_valid_o, memwb_valid_o;
  logic       ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o, timeout_o;
  logic [c_CNT_W-1:0] stall_cycles_o, flush_events_o;

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(
    .REG_ADDR_W (5),
    .WAIT_MAX   (c_WAIT_MAX),
    .CNT_W      (c_CNT_W)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .id_rs_i           (id_rs_i),
    .id_rt_i           (id_rt_i),
    .ex_rt_i           (ex_rt_i),
    .ex_mem_read_i     (ex_mem_read_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .mem_access_i      (mem_access_i),
    .dmem_ready_i      (dmem_ready_i),
    .pc_write_o        (pc_write_o),
    .ifid_valid_o      (ifid_valid_o),
    .idex_valid_o      (idex_valid_o),
    .exmem_valid_o     (exmem_valid_o),
    .memwb_valid_o     (memwb_valid_o),
    .ifid_flush_o      (ifid_flush_o),
    .idex_flush_o      (idex_flush_o),
    .exmem_flush_o     (exmem_flush_o),
    .memwb_flush_o     (memwb_flush_o),
    .timeout_o         (timeout_o),
    .stall_cycles_o    (stall_cycles_o),
    .flush_events_o    (flush_events_o)
  );

  // Expected view of one cycle: strobes for this cycle, registers as they stand
  typedef struct {
    logic [8:0] strobes;  // {pc, ifid_v, idex_v, exmem_v, memwb_v, ifid_f, idex_f, exmem_f, memwb_f}
    logic       tmo;
    int         stall;
    int         flush;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: counts of events, not hardware registers
  int   m_not_ready_run = 0;
  bit   m_timeout       = 0;
  int   m_stall         = 0;
  int   m_flush         = 0;

  // One stimulus cycle: drive inputs, predict outputs, advance the model
  task automatic cyc(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] ext, input logic mr, input logic br,
                     input logic ma, input logic rdy);
    exp_t e;
    bit   frz, lu;
    @(posedge clk_i);
    #1;
    rst_i = rst; id_rs_i = rs; id_rt_i = rt; ex_rt_i = ext;
    ex_mem_read_i = mr; ex_branch_taken_i = br; mem_access_i = ma; dmem_ready_i = rdy;
    frz = ma && !rdy;
    lu  = mr && (ext != 0) && (ext == rs || ext == rt);
    if (rst)      e.strobes = 9'b0_0000_1111;
    else if (frz) e.strobes = 9'b0_0001_0001;
    else if (br)  e.strobes = 9'b1_1111_1100;
    else if (lu)  e.strobes = 9'b0_0111_0100;
    else          e.strobes = 9'b1_1111_0000;
    e.tmo   = m_timeout;
    e.stall = m_stall;
    e.flush = m_flush;
    sb_q.push_back(e);
    if (rst) begin
      m_not_ready_run = 0; m_timeout = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_not_ready_run = frz ? m_not_ready_run + 1 : 0;
      if (m_not_ready_run >= c_WAIT_MAX) m_timeout = 1;
      if (!e.strobes[8] && m_stall < c_CNT_MAX) m_stall++;
      if (!frz && br && m_flush < c_CNT_MAX) m_flush++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: every cycle, compare the DUT against the oldest prediction
  initial begin : monitor
    exp_t e;
    logic [8:0] got;
    forever begin
      @(negedge clk_i);
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        got = {pc_write_o, ifid_valid_o, idex_valid_o, exmem_valid_o, memwb_valid_o,
               ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o};
        n_checks++;
        if (got !== e.strobes) begin
          n_errors++;
          $display("FAIL strobes t=%0t got=%b exp=%b", $time, got, e.strobes);
        end
        n_checks++;
        if (timeout_o !== e.tmo) begin
          n_errors++;
          $display("FAIL timeout t=%0t got=%b exp=%b", $time, timeout_o, e.tmo);
        end
        n_checks++;
        if (stall_cycles_o !== c_CNT_W'(e.stall)) begin
          n_errors++;
          $display("FAIL stall_cycles t=%0t got=%0d exp=%0d", $time, stall_cycles_o, e.stall);
        end
        n_checks++;
        if (flush_events_o !== c_CNT_W'(e.flush)) begin
          n_errors++;
          $display("FAIL flush_events t=%0t got=%0d exp=%0d", $time, flush_events_o, e.flush);
        end
      end
    end
  end

  // Stimulus: directed scenarios, randomized traffic, then saturation
  initial begin : stimulus
    logic ma, rdy;
    repeat (2) @(posedge clk_i);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    // load-use on rs, then on rt, then no false stall on r0
    cyc(0, 5, 0, 5, 1, 0, 0, 1);
    idle(1);
    cyc(0, 1, 7, 7, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 0, 1);
    idle(1);
    // taken branch
    cyc(0, 0, 0, 0, 0, 1, 0, 1);
    idle(1);
    // 3-cycle memory wait, release on the 4th
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    // branch during freeze is ignored, applied on release
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 1);
    idle(1);
    // timeout after 4 not-ready cycles, sticky past ready
    repeat (6) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // reset pulse mid-wait
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ma  = ($urandom_range(0, 9) < 3);
      rdy = ma ? ($urandom_range(0, 1) == 1) : 1'b1;
      cyc(($urandom_range(0, 99) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
          ma, rdy);
    end
    // saturation of both counters
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    repeat (70) cyc(0, 3, 0, 3, 1, 0, 0, 1);
    repeat (70) cyc(0, 0, 0, 0, 0, 1, 0, 1);
    idle(2);
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain got=%0d pending exp=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_hazard_ctrl
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage CPU. It generates the per-stage enable (`valid`) and flush strobes that drive the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable. It handles three cases: load-use stalls, taken-branch flushes and multi-cycle data-memory waits. The memory-wait case uses a small state machine with a timeout watchdog, and the block keeps saturating stall/flush performance counters.

## Interface
- `REG_ADDR_W`, 5, register-file address width
- `WAIT_MAX`, 255, memory-wait cycles before `timeout_o` sets (≥1)
- `CNT_W`, 16, performance counter width

- `clk_i` in 1: clock
- `rst_i` in 1: reset, synchronous, active-high
- `id_rs_i` in REG_ADDR_W: rs of instruction in ID
- `id_rt_i` in REG_ADDR_W: rt of instruction in ID
- `ex_rt_i` in REG_ADDR_W: destination of instruction in EX
- `ex_mem_read_i` in 1: instruction in EX is a load
- `ex_branch_taken_i` in 1: branch in EX resolved taken
- `mem_access_i` in 1: instruction in MEM accesses data memory
- `dmem_ready_i` in 1: data memory completes access this cycle
- `pc_write_o` out 1: PC update enable
- `ifid_valid_o`, `idex_valid_o`, `exmem_valid_o`, `memwb_valid_o` out 1 each: pipe-register load enables
- `ifid_flush_o`, `idex_flush_o`, `exmem_flush_o`, `memwb_flush_o` out 1 each: clear control field of pipe register
- `timeout_o` out 1: sticky memory-wait timeout
- `stall_cycles_o` out CNT_W: cycles with `pc_write_o`=0 (saturating)
- `flush_events_o` out CNT_W: taken-branch flushes applied (saturating)

## Operation
- Strobe outputs are combinational from state and inputs. Counters, `timeout_o`, state and the wait counter are registered.
- While `rst_i`=1:
  - `pc_write_o`=0, all valid=0, all flush=1.
  - Next edge: state=RUN, wait_cnt=0, `timeout_o`=0, both counters=0.
- Default (no hazard): `pc_write_o`=1, all valid=1, all flush=0.
- Freeze, when memory is not ready (`mem_access_i` & !`dmem_ready_i`, in either state):
  - `pc_write_o`=0; ifid/idex/exmem valid=0.
  - `memwb_valid_o`=1 and `memwb_flush_o`=1, so a bubble enters WB.
- Load-use, when `ex_mem_read_i` & `ex_rt_i`≠0 & (`ex_rt_i`==`id_rs_i` | `ex_rt_i`==`id_rt_i`):
  - `pc_write_o`=0, `ifid_valid_o`=0, `idex_valid_o`=1, `idex_flush_o`=1.
  - All other strobes take their default values.
- Branch taken:
  - `ifid_flush_o`=1, `idex_flush_o`=1.
  - All valid=1, `pc_write_o`=1.
- Priority: freeze > branch > load-use. When a freeze is active, branch and load-use are ignored for that cycle and re-evaluated once the pipeline is released.
- FSM states:
  - RUN: on freeze condition → MEM_WAIT, with wait_cnt=1.
  - MEM_WAIT: while !`dmem_ready_i`, stay and increment wait_cnt (saturates at WAIT_MAX). When `dmem_ready_i`=1, release in that same cycle (no freeze) → RUN, wait_cnt=0.
  - wait_cnt reaching WAIT_MAX sets `timeout_o`. It stays set until reset; the FSM keeps waiting.
- Counters:
  - `stall_cycles_o` increments on every cycle with `pc_write_o`=0 and `rst_i`=0.
  - `flush_events_o` increments on every cycle where the branch flush is actually applied.
  - Both saturate at all-ones.
- `exmem_flush_o` is never asserted except during reset. It is reserved for future MEM-stage branch resolution.

## Timing
- Strobes take effect at the same clock edge that samples the hazard (zero-cycle latency). Pipe registers update on that edge.
- Load-use stall lasts exactly 1 cycle: the load moves to MEM and the compare clears.
- Memory wait of N not-ready cycles gives N freeze cycles. The pipeline advances on the cycle `dmem_ready_i`=1.
- `timeout_o` rises on the edge at which wait_cnt becomes WAIT_MAX, which is the WAIT_MAX-th consecutive not-ready cycle.
- Reset asserted mid-wait returns the block to RUN at the next edge, discarding the wait. Counters clear.
- Counter saturation: at all-ones, an increment condition leaves the value unchanged.

## Structure
- Package `hazard_pkg`: FSM state enum (RUN, MEM_WAIT), default widths.
- Sub-module `sat_counter`, parameterised by width, with inc/clear. It is instantiated twice, for the stall and flush counters.
- Top level `hazard_ctrl`: contains the hazard compare, priority mux, FSM and wait counter.

## Test plan
- Load-use: `ex_mem_read_i`=1, `ex_rt_i`=5, `id_rs_i`=5 for 1 cycle → `pc_write_o`=0, `ifid_valid_o`=0, `idex_flush_o`=1 in that cycle; `stall_cycles_o`=1.
- No false stall: `ex_mem_read_i`=1, `ex_rt_i`=0, `id_rs_i`=0 → default strobes; `stall_cycles_o` unchanged.
- Branch: `ex_branch_taken_i`=1 for 1 cycle → `ifid_flush_o`=`idex_flush_o`=1, `pc_write_o`=1; `flush_events_o`=1.
- Memory wait: `mem_access_i`=1, `dmem_ready_i`=0 for 3 cycles, then 1 → 3 freeze cycles with `memwb_flush_o`=1, release on the 4th; `stall_cycles_o`+=3; state back to RUN.
- Timeout: WAIT_MAX=4, not-ready for 6 cycles → `timeout_o`=1 after the 4th cycle and stays set after ready; `rst_i` clears it.
- Simultaneous events and reset:
  - Branch taken during freeze → no flush, `flush_events_o` unchanged; branch flush applied on the release cycle.
  - `rst_i` pulse mid-wait → RUN, counters 0.
